// File: rtl/rf_writeback_unit_pkg.sv
// rtl/rf_writeback_unit_pkg.sv - shared widths and FIFO entry type for the writeback unit
package rf_writeback_unit_pkg;

    localparam int REGISTER_FILE_ADDRESS_WIDTH = 5;
    localparam int REGISTER_FILE_NUM           = 32;
    localparam int RISC_V_DATA_WIDTH           = 32;

    // One buffered long-latency result: destination register and value.
    typedef struct packed {
        logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] rd;
        logic [RISC_V_DATA_WIDTH-1:0]           data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_unit_if.sv
// rtl/rf_writeback_unit_if.sv - execute/decode/register-file signal bundle of the writeback unit
interface rf_writeback_unit_if
    import rf_writeback_unit_pkg::*;
#(
    parameter int WB_FIFO_DEPTH = 2
);

    localparam int LEVEL_W = $clog2(WB_FIFO_DEPTH) + 1;

    // ALU result, no backpressure
    logic                                   alu_valid;
    logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] alu_rd;
    logic [RISC_V_DATA_WIDTH-1:0]           alu_data;

    // Long-latency result stream
    logic                                   ll_valid;
    logic                                   ll_ready;
    logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ll_rd;
    logic [RISC_V_DATA_WIDTH-1:0]           ll_data;

    // Decode side: issue of long-latency ops and hazard queries
    logic                                   issue_ll_valid;
    logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] issue_ll_rd;
    logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] query_rs0;
    logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] query_rs1;
    logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] query_rd;
    logic                                   stall;

    // Register file write port
    logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_num_w;
    logic [RISC_V_DATA_WIDTH-1:0]           w_data;
    logic                                   ctrl_reg_w;

    // Debug / status
    logic [REGISTER_FILE_NUM-1:0]           pending;
    logic [LEVEL_W-1:0]                     fifo_level;

    // Producer side (execute, decode and anything observing the write port)
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ll_valid, ll_rd, ll_data,
        input  ll_ready,
        output issue_ll_valid, issue_ll_rd,
        output query_rs0, query_rs1, query_rd,
        input  stall,
        input  reg_num_w, w_data, ctrl_reg_w,
        input  pending, fifo_level
    );

    // The writeback unit itself
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ll_valid, ll_rd, ll_data,
        output ll_ready,
        input  issue_ll_valid, issue_ll_rd,
        input  query_rs0, query_rs1, query_rd,
        output stall,
        output reg_num_w, w_data, ctrl_reg_w,
        output pending, fifo_level
    );

endinterface

// File: rtl/rf_writeback_unit_wb_fifo.sv
// rtl/rf_writeback_unit_wb_fifo.sv - small synchronous FIFO buffering long-latency results
module wb_fifo
    import rf_writeback_unit_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  wb_entry_t          push_data,
    input  logic               pop,
    output wb_entry_t          pop_data,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] count;
    logic               do_push;
    logic               do_pop;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt the count.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (count == '0);
    assign full     = (count == LEVEL_W'(DEPTH));
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + LEVEL_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - LEVEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/rf_writeback_unit.sv
// rtl/rf_writeback_unit.sv - merges ALU and long-latency results onto the register file write port
module rf_writeback_unit
    import rf_writeback_unit_pkg::*;
#(
    parameter int REGISTER_FILE_ADDRESS_WIDTH = rf_writeback_unit_pkg::REGISTER_FILE_ADDRESS_WIDTH,
    parameter int REGISTER_FILE_NUM           = rf_writeback_unit_pkg::REGISTER_FILE_NUM,
    parameter int RISC_V_DATA_WIDTH           = rf_writeback_unit_pkg::RISC_V_DATA_WIDTH,
    parameter int WB_FIFO_DEPTH               = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_writeback_unit_if.slave   bus
);

    localparam int LEVEL_W = $clog2(WB_FIFO_DEPTH) + 1;

    wb_entry_t                              fifo_head;
    logic                                   fifo_full;
    logic                                   fifo_empty;
    logic                                   fifo_push;
    logic                                   fifo_pop;
    logic [LEVEL_W-1:0]                     fifo_level;
    wb_entry_t                              push_entry;

    logic                                   ctrl_reg_w_r;
    logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_num_w_r;
    logic [RISC_V_DATA_WIDTH-1:0]           w_data_r;
    logic                                   src_ll_r;

    logic                                   ctrl_reg_w_n;
    logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_num_w_n;
    logic [RISC_V_DATA_WIDTH-1:0]           w_data_n;
    logic                                   src_ll_n;

    logic [REGISTER_FILE_NUM-1:0]           pending_r;
    logic [REGISTER_FILE_NUM-1:0]           pending_n;

    // ll_ready depends only on current occupancy: no pass-through on a same-cycle pop.
    assign fifo_push       = bus.ll_valid && !fifo_full;
    assign push_entry.rd   = bus.ll_rd;
    assign push_entry.data = bus.ll_data;
    // ALU results always win the write port; the FIFO drains only on ALU-idle cycles.
    assign fifo_pop        = !bus.alu_valid && !fifo_empty;

    wb_fifo #(
        .DEPTH (WB_FIFO_DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Output stage next value: ALU first, then FIFO head; rd=0 never raises the write strobe.
    always_comb begin
        ctrl_reg_w_n = 1'b0;
        reg_num_w_n  = reg_num_w_r;
        w_data_n     = w_data_r;
        src_ll_n     = 1'b0;
        if (bus.alu_valid) begin
            ctrl_reg_w_n = (bus.alu_rd != '0);
            reg_num_w_n  = bus.alu_rd;
            w_data_n     = bus.alu_data;
            src_ll_n     = 1'b0;
        end else if (!fifo_empty) begin
            ctrl_reg_w_n = (fifo_head.rd != '0);
            reg_num_w_n  = fifo_head.rd;
            w_data_n     = fifo_head.data;
            src_ll_n     = 1'b1;
        end
    end

    // Output stage register feeding the register file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_reg_w_r <= 1'b0;
            reg_num_w_r  <= '0;
            w_data_r     <= '0;
            src_ll_r     <= 1'b0;
        end else begin
            ctrl_reg_w_r <= ctrl_reg_w_n;
            reg_num_w_r  <= reg_num_w_n;
            w_data_r     <= w_data_n;
            src_ll_r     <= src_ll_n;
        end
    end

    // Scoreboard update: clear on a completing long-latency write, then set on issue so set wins.
    always_comb begin
        pending_n = pending_r;
        if (ctrl_reg_w_r && src_ll_r) begin
            pending_n[reg_num_w_r] = 1'b0;
        end
        if (bus.issue_ll_valid && (bus.issue_ll_rd != '0)) begin
            pending_n[bus.issue_ll_rd] = 1'b1;
        end
        pending_n[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_n;
        end
    end

    // A register is hazardous if a long-latency write is outstanding or its write is on the port now.
    function automatic logic reg_busy(
        input logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] q,
        input logic [REGISTER_FILE_NUM-1:0]           pend,
        input logic                                   wr_en,
        input logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] wr_num
    );
        return (q != '0) && (pend[q] || (wr_en && (wr_num == q)));
    endfunction

    // Decode stall across both operands and the destination.
    always_comb begin
        bus.stall = 1'b0;
        if (reg_busy(bus.query_rs0, pending_r, ctrl_reg_w_r, reg_num_w_r) ||
            reg_busy(bus.query_rs1, pending_r, ctrl_reg_w_r, reg_num_w_r) ||
            reg_busy(bus.query_rd,  pending_r, ctrl_reg_w_r, reg_num_w_r)) begin
            bus.stall = 1'b1;
        end
    end

    assign bus.ll_ready   = !fifo_full;
    assign bus.ctrl_reg_w = ctrl_reg_w_r;
    assign bus.reg_num_w  = reg_num_w_r;
    assign bus.w_data     = w_data_r;
    assign bus.pending    = pending_r;
    assign bus.fifo_level = fifo_level;

endmodule

// File: doc/rf_writeback_unit.md
# rf_writeback_unit

Write-side controller for the integer register file. It merges single-cycle ALU results with results from a long-latency unit (load/store or multiply) into the register file's single write port, buffering long-latency results in a small FIFO. It also keeps a 32-entry pending-write scoreboard so decode can stall on operands or destinations that have not yet been written. It sits between execute/memory and the register file write port (`reg_num_w`, `w_data`, `ctrl_reg_w`).

## Interface
Parameters:
- `REGISTER_FILE_ADDRESS_WIDTH`, 5, register index width
- `REGISTER_FILE_NUM`, 32, number of architectural registers
- `RISC_V_DATA_WIDTH`, 32, data width
- `WB_FIFO_DEPTH`, 2, long-latency result buffer entries (power of two, ≥2)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `alu_valid` in 1: ALU result present this cycle (no backpressure)
- `alu_rd` in 5: ALU destination
- `alu_data` in 32: ALU result
- `ll_valid` in 1: long-latency result offered
- `ll_ready` out 1: FIFO can accept
- `ll_rd` in 5: long-latency destination
- `ll_data` in 32: long-latency result
- `issue_ll_valid` in 1: decode issues a long-latency instruction this cycle
- `issue_ll_rd` in 5: its destination
- `query_rs0`, `query_rs1`, `query_rd` in 5 each: decode's current operands and destination
- `stall` out 1: decode must hold
- `reg_num_w` out 5, `w_data` out 32, `ctrl_reg_w` out 1: register file write port
- `pending` out 32: scoreboard bits (debug)
- `fifo_level` out $clog2(WB_FIFO_DEPTH)+1: FIFO occupancy

## Operation
- Output stage is a register (`ctrl_reg_w`, `reg_num_w`, `w_data`, plus an internal `src_ll` flag). It is loaded on every edge by the following priority:
  1. `alu_valid`: load the ALU result; `src_ll`=0.
  2. Otherwise, FIFO non-empty: load the FIFO head, pop it; `src_ll`=1.
  3. Otherwise: `ctrl_reg_w`=0.
- A write with rd=0 loads the stage with `ctrl_reg_w`=0; a FIFO pop still occurs.
- FIFO push: `ll_valid && ll_ready`. `ll_ready` = !full, computed from current occupancy only. There is no ready pass-through on same-cycle pop and no bypass around the FIFO.
- Scoreboard set: `issue_ll_valid` with `issue_ll_rd`≠0 sets `pending[rd]`.
- Scoreboard clear: at the edge ending a cycle where `ctrl_reg_w && src_ll`, clear `pending[reg_num_w]`. If set and clear hit the same bit on the same edge, set wins.
- `pending[0]` is always 0.
- `stall` (combinational) is 1 if any of `query_rs0`, `query_rs1`, `query_rd` is nonzero and either:
  - its pending bit is set, or
  - it equals `reg_num_w` while `ctrl_reg_w`=1 (write in flight).
- Decode is responsible for not issuing while `stall`=1. The unit does not check this.

## Timing
- Reset (async, immediate): `ctrl_reg_w`=0, `reg_num_w`=0, `w_data`=0, `src_ll`=0, `pending`=0, FIFO empty, `fifo_level`=0, `ll_ready`=1, `stall`=0. Reset asserted mid-operation discards buffered results and scoreboard state.
- ALU path: `alu_valid` in cycle N → `ctrl_reg_w`=1 in N+1 → register file updated at end of N+1.
- Long-latency path: accepted in N → earliest `ctrl_reg_w` in N+2 (if `alu_valid`=0 in N+1) → pending bit clear and register file update at end of N+2.
- Every cycle with `alu_valid`=1 delays the FIFO drain by one cycle.
- FIFO full: `ll_ready`=0. The producer holds `ll_valid`/`ll_rd`/`ll_data` stable until accepted.
- Pointers wrap modulo `WB_FIFO_DEPTH`. Simultaneous push and pop leaves `fifo_level` unchanged.

## Structure
- Shared package holds `REGISTER_FILE_ADDRESS_WIDTH`, `REGISTER_FILE_NUM`, `RISC_V_DATA_WIDTH`, and a `wb_entry_t` struct (rd, data).
- One sub-module, `wb_fifo`: parameterized synchronous FIFO of `wb_entry_t` with push, pop, full, empty and level outputs, using asynchronous active-high reset.
- The scoreboard, output stage and stall logic live in the top module.

## Test plan
- Reset with `ll_valid`=1, then release: all outputs 0, `ll_ready`=1, `pending`=0; no write during or immediately after reset.
- `alu_valid`=1, rd=7, data 0xDEADBEEF in cycle 1: `ctrl_reg_w`=1, `reg_num_w`=7, `w_data`=0xDEADBEEF in cycle 2. `query_rs0`=7 gives `stall`=1 in cycle 2 only.
- Issue LL rd=5, then `ll_valid` rd=5, data 0x1234 with `alu_valid` high for 3 cycles:
  - `stall` stays 1 for `query_rs1`=5 throughout.
  - Write appears the cycle after ALU goes idle.
  - `pending[5]` clears at the end of that cycle.
- Push 3 LL results back-to-back while `alu_valid`=1 (depth 2): `ll_ready` drops after 2 accepts, `fifo_level`=2. The third result is accepted once the drain starts, and all 3 are written in order.
- ALU rd=0 and LL rd=0: `ctrl_reg_w` stays 0, the FIFO still drains, and `pending[0]` never sets.
- Assert `rst` with the FIFO holding 2 entries and `pending`=0x0000_0060: immediate clear, and no write of the discarded entries after release.
